// File: rtl/datapath_pkg.sv
// Shared definitions for the 5-stage datapath.
// Holds the opcode constants, the ALUOp encodings, the control bundle widths
// and the decode helpers used by the decode stage and its register file.
package datapath_pkg;

    localparam int WB_W   = 2;
    localparam int M_W    = 3;
    localparam int EX_W   = 4;
    localparam int REG_AW = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    // wb = {RegWrite, MemtoReg}, m = {Branch, MemRead, MemWrite},
    // ex = {RegDst, ALUOp[1:0], ALUSrc}
    typedef struct packed {
        logic [WB_W-1:0] wb;
        logic [M_W-1:0]  m;
        logic [EX_W-1:0] ex;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = ctrl_t'({(WB_W + M_W + EX_W){1'b0}});

    // Control decode of a 32-bit instruction word. The all-zero word is the
    // flush/no-op pattern and must not write r0-style garbage back, so it
    // yields an all-zero bundle even though its opcode is R-type.
    function automatic ctrl_t decode_ctrl(input logic [31:0] instr);
        ctrl_t c;
        c = CTRL_NOP;
        case (instr[31:26])
            OP_RTYPE: begin
                if (instr != 32'h0000_0000) begin
                    c.wb = 2'b10;
                    c.ex = {1'b1, ALUOP_FUNC, 1'b0};
                end else begin
                    c = CTRL_NOP;
                end
            end
            OP_LW: begin
                c.wb = 2'b11;
                c.m  = 3'b010;
                c.ex = {1'b0, ALUOP_ADD, 1'b1};
            end
            OP_SW: begin
                c.m  = 3'b001;
                c.ex = {1'b0, ALUOP_ADD, 1'b1};
            end
            OP_BEQ: begin
                c.m  = 3'b100;
                c.ex = {1'b0, ALUOP_SUB, 1'b0};
            end
            default: c = CTRL_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/i_decode_reg_file.sv
// 32x32 register file for the decode stage.
// Ports: clk/rst (sync, active-high, clears all registers), two combinational
// read ports (rd_addr1/rd_data1, rd_addr2/rd_data2) and one synchronous write
// port (wr_en, wr_addr, wr_data). Register 0 always reads zero, and a read of
// the register being written in the same cycle returns the new data.
module reg_file
    import datapath_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rd_addr1,
    input  logic [REG_AW-1:0] rd_addr2,
    output logic [DWIDTH-1:0] rd_data1,
    output logic [DWIDTH-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DWIDTH-1:0] wr_data
);

    logic [DWIDTH-1:0] regs_r [NREGS];
    logic              wr_live_s;

    // A write to r0 is discarded, so it must not bypass either.
    assign wr_live_s = wr_en && (wr_addr != {REG_AW{1'b0}});

    // Storage: reset clear has priority, so no write lands on a reset edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {DWIDTH{1'b0}};
            end
        end else if (wr_live_s) begin
            regs_r[wr_addr] <= wr_data;
        end
    end

    // Read port 1 with zero register and write-back bypass.
    always_comb begin
        if (rd_addr1 == {REG_AW{1'b0}}) begin
            rd_data1 = {DWIDTH{1'b0}};
        end else if (wr_live_s && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end else begin
            rd_data1 = regs_r[rd_addr1];
        end
    end

    // Read port 2 with zero register and write-back bypass.
    always_comb begin
        if (rd_addr2 == {REG_AW{1'b0}}) begin
            rd_data2 = {DWIDTH{1'b0}};
        end else if (wr_live_s && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end else begin
            rd_data2 = regs_r[rd_addr2];
        end
    end

endmodule

// File: rtl/i_decode.sv
// Instruction-decode stage: IF/ID latch, register file read with write-back
// bypass, control decode (R-type, lw, sw, beq) and the ID/EX latch.
// Ports: clk, rst (sync, active-high); instr_in/npc_in from fetch; stall holds
// IF/ID and bubbles ID/EX; flush zeroes IF/ID and bubbles ID/EX (flush wins
// over stall); wb_* is the write-back port; id_ex_* are the registered
// control bundles and data fields for execute.
module i_decode
    import datapath_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] instr_in,
    input  logic [DWIDTH-1:0] npc_in,
    input  logic              stall,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_write_reg,
    input  logic [DWIDTH-1:0] wb_write_data,
    output logic [WB_W-1:0]   id_ex_wb,
    output logic [M_W-1:0]    id_ex_m,
    output logic [EX_W-1:0]   id_ex_ex,
    output logic [DWIDTH-1:0] id_ex_npc,
    output logic [DWIDTH-1:0] id_ex_readdat1,
    output logic [DWIDTH-1:0] id_ex_readdat2,
    output logic [DWIDTH-1:0] id_ex_sign_ext,
    output logic [4:0]        id_ex_instr_2016,
    output logic [4:0]        id_ex_instr_1511
);

    logic [DWIDTH-1:0] if_id_instr_r;
    logic [DWIDTH-1:0] if_id_npc_r;
    logic [DWIDTH-1:0] rd_data1_s;
    logic [DWIDTH-1:0] rd_data2_s;
    logic [DWIDTH-1:0] sign_ext_s;
    ctrl_t             ctrl_s;

    reg_file #(
        .DWIDTH (DWIDTH),
        .NREGS  (NREGS)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .rd_addr1 (if_id_instr_r[25:21]),
        .rd_addr2 (if_id_instr_r[20:16]),
        .rd_data1 (rd_data1_s),
        .rd_data2 (rd_data2_s),
        .wr_en    (wb_reg_write),
        .wr_addr  (wb_write_reg),
        .wr_data  (wb_write_data)
    );

    assign ctrl_s     = decode_ctrl(if_id_instr_r[31:0]);
    assign sign_ext_s = {{(DWIDTH-16){if_id_instr_r[15]}}, if_id_instr_r[15:0]};

    // IF/ID latch: flush loads the no-op word, stall holds.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            if_id_instr_r <= {DWIDTH{1'b0}};
            if_id_npc_r   <= {DWIDTH{1'b0}};
        end else if (!stall) begin
            if_id_instr_r <= instr_in;
            if_id_npc_r   <= npc_in;
        end
    end

    // ID/EX latch: flush or stall inject a bubble; data fields keep their
    // last value since execute ignores them when every control is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_wb         <= {WB_W{1'b0}};
            id_ex_m          <= {M_W{1'b0}};
            id_ex_ex         <= {EX_W{1'b0}};
            id_ex_npc        <= {DWIDTH{1'b0}};
            id_ex_readdat1   <= {DWIDTH{1'b0}};
            id_ex_readdat2   <= {DWIDTH{1'b0}};
            id_ex_sign_ext   <= {DWIDTH{1'b0}};
            id_ex_instr_2016 <= 5'd0;
            id_ex_instr_1511 <= 5'd0;
        end else if (flush || stall) begin
            id_ex_wb <= {WB_W{1'b0}};
            id_ex_m  <= {M_W{1'b0}};
            id_ex_ex <= {EX_W{1'b0}};
        end else begin
            id_ex_wb         <= ctrl_s.wb;
            id_ex_m          <= ctrl_s.m;
            id_ex_ex         <= ctrl_s.ex;
            id_ex_npc        <= if_id_npc_r;
            id_ex_readdat1   <= rd_data1_s;
            id_ex_readdat2   <= rd_data2_s;
            id_ex_sign_ext   <= sign_ext_s;
            id_ex_instr_2016 <= if_id_instr_r[20:16];
            id_ex_instr_1511 <= if_id_instr_r[15:11];
        end
    end

endmodule

// File: doc/i_decode.md
# i_decode

Instruction-decode stage of the 5-stage datapath, directly downstream of `i_fetch`. It latches `instr_out`/`npc` in an IF/ID register and reads a 32×32 register file with write-back bypass. It decodes the MIPS subset (R-type, lw, sw, beq) into WB/M/EX control bundles and registers everything into the ID/EX latch consumed by the execute stage. It also honours stall (hazard hold) and flush (taken branch, `PCSrc`) requests.

## Interface
Parameters:
- `DWIDTH`, 32, datapath and instruction width
- `NREGS`, 32, register file depth; index width is 5

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `instr_in`  in  32  instruction from fetch (`instr_out`)
- `npc_in`  in  32  PC+4 from fetch (`npc`)
- `stall`  in  1  hold IF/ID, inject bubble into ID/EX
- `flush`  in  1  taken branch (`PCSrc`); squash IF/ID and ID/EX
- `wb_reg_write`  in  1  write-back enable
- `wb_write_reg`  in  5  write-back destination
- `wb_write_data`  in  32  write-back data
- `id_ex_wb`  out  2  {RegWrite, MemtoReg}
- `id_ex_m`  out  3  {Branch, MemRead, MemWrite}
- `id_ex_ex`  out  4  {RegDst, ALUOp[1:0], ALUSrc}
- `id_ex_npc`  out  32  registered npc
- `id_ex_readdat1`, `id_ex_readdat2`  out  32 each  rs/rt operands
- `id_ex_sign_ext`  out  32  sign-extended instr[15:0]
- `id_ex_instr_2016`, `id_ex_instr_1511`  out  5 each  rt, rd fields

## Operation
- IF/ID register (`if_id_instr`, `if_id_npc`) behaviour:
  - `flush`: loads 0. Opcode 0 with all fields 0 decodes as a no-op with RegWrite forced 0.
  - else `stall`: holds.
  - else: loads `instr_in`/`npc_in`.
- Decode of `if_id_instr[31:26]`:
  - 000000 (R-type): RegDst=1, ALUOp=10, ALUSrc=0, RegWrite=1. The instruction word 0 is special-cased: all controls 0.
  - 100011 (lw): ALUOp=00, ALUSrc=1, MemRead=1, RegWrite=1, MemtoReg=1.
  - 101011 (sw): ALUOp=00, ALUSrc=1, MemWrite=1.
  - 000100 (beq): ALUOp=01, Branch=1.
  - any other opcode: all control bits 0 (bubble); data fields still latched.
- Register file:
  - Write on rising edge when `wb_reg_write` and `wb_write_reg`≠0.
  - Register 0 reads 0 always.
  - Reads are combinational with bypass: if a write targets the read index (non-zero) in the same cycle, the read returns `wb_write_data`.
- ID/EX register:
  - `flush` or `stall`: all control bundles 0; data fields don't-care but held at their loaded value.
  - else: loads decode outputs, operands, sign extension {16{i[15]}, i[15:0]}, rt=i[20:16], rd=i[15:11], `if_id_npc`.
- Priority: `rst` > `flush` > `stall` > normal.

## Timing
- Reset (synchronous):
  - IF/ID and all ID/EX outputs are 0 on the first edge with `rst`=1.
  - All 32 registers are cleared.
  - Outputs remain 0 until an instruction is loaded post-reset.
- Latency: an instruction presented on `instr_in` at edge N is in IF/ID after N. Its decode appears on `id_ex_*` after edge N+1 (2 edges, no bubbles).
- Stall:
  - One bubble per stalled cycle.
  - The held IF/ID instruction is decoded on the first non-stalled edge.
  - Back-to-back stalls keep inserting bubbles.
- Flush:
  - Squashes both latches on that edge.
  - Flush asserted together with stall is a flush.
- Write-back and decode read of the same register in the same cycle: the new value is visible (bypass). The write is committed at the same edge.
- Reset mid-stream: all in-flight instructions are lost. No partial register write occurs on the reset edge.

## Structure
- Shared package `datapath_pkg` holds:
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`
  - ALUOp encodings `ALUOP_ADD`=00, `ALUOP_SUB`=01, `ALUOP_FUNC`=10
  - control bundle widths WB=2, M=3, EX=4
- Sub-module `reg_file`:
  - two combinational read ports, one synchronous write port
  - bypass logic, zero register, reset clear
- Control decode and both latches live in `i_decode`.

## Test plan
- Reset, then feed lw (0x8C220004) with r1=0x10 preloaded via write-back:
  - after 2 edges: `id_ex_wb`=11, `id_ex_m`=010, `id_ex_ex`=0001, `readdat1`=0x10, `sign_ext`=0x4
- R-type add (0x00221820) with r1=5 and r2=7 preloaded:
  - `id_ex_ex`=1100, `readdat1`=5, `readdat2`=7, `instr_1511`=3
- Write-back r4←0xDEADBEEF in the same cycle that a sw reading r4 is in ID:
  - `readdat2`=0xDEADBEEF
  - write-back to r0 leaves `readdat` of r0 at 0
- Stall asserted 2 cycles while beq (0x10220003) is in IF/ID:
  - two bubbles (all controls 0), then beq: `id_ex_m`=100, ALUOp=01
- Flush with stall both asserted while lw is in IF/ID:
  - next `id_ex_*` controls 0; IF/ID=0
  - the following instruction proceeds normally
- Negative immediate beq offset 0xFFFC:
  - `sign_ext`=0xFFFFFFFC
  - unknown opcode 0x3F: all controls 0
